cell_pos_pingpong: RTL and testbench

- Per-cell particle position store that replaces the single-port cell RAM.
- Two banks, used ping-pong:
  - the active bank serves force-evaluation reads;
  - the shadow bank collects motion-update appends for the next iteration.
- Bank roles exchange on an iteration-boundary swap.
- Address 0 of each bank reads as the bank's particle count, so existing readers keep their addressing convention.

---
 rtl/pos_cell_pkg.sv | 21 ++
 rtl/sdp_ram_2p.sv | 35 +++
 rtl/cell_pos_pingpong.sv | 152 +++++++++++++++
 tb/tb_cell_pos_pingpong.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/pos_cell_pkg.sv
// Shared definitions for the per-cell particle position store.
// A position word packs three 32-bit components as {posz, posy, posx}.
package pos_cell_pkg;

    localparam int POS_COMP_WIDTH = 32;
    localparam int POS_DATA_WIDTH = 3 * POS_COMP_WIDTH;

    // Slot 0 of every bank reads back as that bank's particle count.
    localparam int COUNT_SLOT = 0;

    typedef logic [POS_DATA_WIDTH-1:0] pos_word_t;

    function automatic pos_word_t pack_pos(
        input logic [POS_COMP_WIDTH-1:0] posx,
        input logic [POS_COMP_WIDTH-1:0] posy,
        input logic [POS_COMP_WIDTH-1:0] posz
    );
        return {posz, posy, posx};
    endfunction

endpackage

// File: rtl/sdp_ram_2p.sv
// Simple dual-port RAM holding both position banks, addressed as {bank, slot}.
// One write port (shadow appends), one registered read port (active reads).
module sdp_ram_2p import pos_cell_pkg::*; #(
    parameter int DATA_WIDTH = POS_DATA_WIDTH,
    parameter int DEPTH      = 220,
    parameter int SLOT_W     = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic                  wr_bank,
    input  logic [SLOT_W-1:0]     wr_slot,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic                  rd_bank,
    input  logic [SLOT_W-1:0]     rd_slot,
    output logic [DATA_WIDTH-1:0] rd_data
);

    // Bank 0 is preloaded from the cell init image at configuration time.
    (* ramstyle = "M20K", ram_init_file = "cell_pos_bank0.mif" *)
    logic [DATA_WIDTH-1:0] mem [2][DEPTH];

    // Write the shadow slot and register the active-bank read.
    // NOTE: no reset here -- a resettable array or output register cannot map onto block RAM,
    // and non-blocking assignments keep the read returning the pre-write contents.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_bank][wr_slot] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_bank][rd_slot];
        end
    end

endmodule

// File: rtl/cell_pos_pingpong.sv
// Ping-pong per-cell position store: the active bank serves force reads while
// the shadow bank collects appends; a swap pulse exchanges the two roles.
module cell_pos_pingpong import pos_cell_pkg::*; #(
    parameter int DATA_WIDTH = POS_DATA_WIDTH,
    parameter int DEPTH      = 220,
    parameter int ADDR_WIDTH = 8,
    parameter int INIT_COUNT = 0
) (
    input  logic                  clock,
    input  logic                  rst_n,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  swap,
    output logic [ADDR_WIDTH-1:0] active_count,
    output logic [ADDR_WIDTH-1:0] shadow_count,
    output logic                  shadow_full,
    output logic                  overflow
);

    localparam int SLOT_W = $clog2(DEPTH);

    localparam logic [ADDR_WIDTH-1:0] LAST_SLOT   = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR  = ADDR_WIDTH'(COUNT_SLOT);
    localparam logic [ADDR_WIDTH-1:0] RESET_COUNT = ADDR_WIDTH'(INIT_COUNT);

    // Where the read result comes from once it reaches the output.
    localparam logic [1:0] SRC_ZERO  = 2'd0;
    localparam logic [1:0] SRC_COUNT = 2'd1;
    localparam logic [1:0] SRC_RAM   = 2'd2;

    logic                  bank_sel;
    logic                  wr_accept;
    logic [ADDR_WIDTH-1:0] wr_slot;

    logic                  s1_valid;
    logic [ADDR_WIDTH-1:0] s1_addr;
    logic                  s1_bank;
    logic [ADDR_WIDTH-1:0] s1_count;
    logic [1:0]            s1_src;

    logic [1:0]            s2_src;
    logic [ADDR_WIDTH-1:0] s2_count;

    logic                  ram_rd_en;
    logic [SLOT_W-1:0]     ram_rd_slot;
    logic [DATA_WIDTH-1:0] ram_q;

    // A full shadow bank drops further appends.
    assign shadow_full = (shadow_count == LAST_SLOT);
    assign wr_accept   = wr_en && !shadow_full;
    assign wr_slot     = shadow_count + ADDR_WIDTH'(1);

    // Bank roles, particle counts and the sticky drop flag.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            bank_sel     <= 1'b0;
            active_count <= RESET_COUNT;
            shadow_count <= '0;
            overflow     <= 1'b0;
        end else begin
            if (swap) begin
                // An append in the swap cycle lands in the bank that becomes active.
                bank_sel     <= ~bank_sel;
                active_count <= wr_accept ? wr_slot : shadow_count;
                shadow_count <= '0;
            end else if (wr_accept) begin
                shadow_count <= wr_slot;
            end
            if (wr_en && shadow_full) begin
                overflow <= 1'b1;
            end
        end
    end

    // Stage 1: capture the request with the bank and count it must be served from.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_bank  <= 1'b0;
            s1_count <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_addr  <= rd_addr;
                s1_bank  <= bank_sel;
                s1_count <= active_count;
            end
        end
    end

    // Decide whether the captured address reads the count, the RAM, or zero.
    // NOTE: always_comb gives every output a value before any branch, so no latch is inferred.
    always_comb begin
        s1_src = SRC_RAM;
        if (s1_addr == COUNT_ADDR) begin
            s1_src = SRC_COUNT;
        end else if ((s1_addr > s1_count) || (s1_addr > LAST_SLOT)) begin
            s1_src = SRC_ZERO;
        end
    end

    // Only touch the RAM for in-range particle slots, so its output holds otherwise.
    assign ram_rd_en   = s1_valid && (s1_src == SRC_RAM);
    assign ram_rd_slot = (s1_src == SRC_RAM) ? SLOT_W'(s1_addr) : SLOT_W'(COUNT_ADDR);

    sdp_ram_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .SLOT_W     (SLOT_W)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_accept),
        .wr_bank (~bank_sel),
        .wr_slot (SLOT_W'(wr_slot)),
        .wr_data (wr_data),
        .rd_en   (ram_rd_en),
        .rd_bank (s1_bank),
        .rd_slot (ram_rd_slot),
        .rd_data (ram_q)
    );

    // Stage 2: result source and count travel alongside the RAM's own output register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid <= 1'b0;
            s2_src   <= SRC_ZERO;
            s2_count <= '0;
        end else begin
            rd_valid <= s1_valid;
            if (s1_valid) begin
                s2_src   <= s1_src;
                s2_count <= s1_count;
            end
        end
    end

    // Final mux; every input to it is frozen between reads, so rd_data holds.
    always_comb begin
        rd_data = '0;
        case (s2_src)
            SRC_COUNT: rd_data = DATA_WIDTH'(s2_count);
            SRC_RAM:   rd_data = ram_q;
            default:   rd_data = '0;
        endcase
    end

endmodule

// File: tb/tb_cell_pos_pingpong.sv
// Directed bench for cell_pos_pingpong with a small bank (DEPTH=8, INIT_COUNT=3).
`timescale 1ns/1ps
module tb_cell_pos_pingpong;
    import pos_cell_pkg::*;

    localparam int DW    = POS_DATA_WIDTH;
    localparam int DEPTH = 8;
    localparam int AW    = 8;
    localparam int INIT  = 3;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          swap;
    logic [AW-1:0] active_count;
    logic [AW-1:0] shadow_count;
    logic          shadow_full;
    logic          overflow;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Read burst description: address, expected data, swap in the same cycle.
    logic [AW-1:0] ra [16];
    logic [DW-1:0] re [16];
    logic          rs [16];
    int            rn;

    cell_pos_pingpong #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .INIT_COUNT (INIT)
    ) dut (
        .clock        (clock),
        .rst_n        (rst_n),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .swap         (swap),
        .active_count (active_count),
        .shadow_count (shadow_count),
        .shadow_full  (shadow_full),
        .overflow     (overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Distinct position word per id: posx=0x100+id, posy=0x200+id, posz=0x300+id.
    function automatic logic [DW-1:0] mk(input int id);
        return pack_pos(32'(32'h100 + id), 32'(32'h200 + id), 32'(32'h300 + id));
    endfunction

    function automatic logic [DW-1:0] cnt(input int n);
        return DW'(n);
    endfunction

    // All tasks start and end just after a falling edge.
    task automatic append(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d;
        @(negedge clock);
        wr_en = 1'b0;
    endtask

    task automatic do_swap();
        swap = 1'b1;
        @(negedge clock);
        swap = 1'b0;
    endtask

    task automatic add_read(input int a, input logic [DW-1:0] e, input logic s);
        ra[rn] = AW'(a); re[rn] = e; rs[rn] = s;
        rn++;
    endtask

    // Back-to-back reads; each result must appear exactly two cycles after its request,
    // and rd_data must hold the last result once rd_valid drops.
    task automatic run_reads(input string tag);
        for (int c = 0; c < rn + 3; c++) begin
            if (c < 2) begin
                check($sformatf("%s_lat%0d", tag, c), DW'(rd_valid), DW'(0));
            end else if (c < rn + 2) begin
                check($sformatf("%s_vld%0d", tag, c - 2), DW'(rd_valid), DW'(1));
                check($sformatf("%s_dat%0d", tag, c - 2), rd_data, re[c-2]);
            end else begin
                check($sformatf("%s_end", tag), DW'(rd_valid), DW'(0));
                check($sformatf("%s_hold", tag), rd_data, re[rn-1]);
            end
            rd_en   = (c < rn);
            rd_addr = (c < rn) ? ra[c] : '0;
            swap    = (c < rn) ? rs[c] : 1'b0;
            @(negedge clock);
        end
        rd_en = 1'b0; swap = 1'b0;
        rn = 0;
    endtask

    initial begin
        rn = 0;
        rst_n = 1'b0; rd_en = 1'b0; rd_addr = '0; wr_en = 1'b0; wr_data = '0; swap = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_valid",  DW'(rd_valid),     DW'(0));
        check("rst_data",   rd_data,           DW'(0));
        check("rst_active", DW'(active_count), cnt(INIT));
        check("rst_shadow", DW'(shadow_count), cnt(0));
        check("rst_full",   DW'(shadow_full),  DW'(0));
        check("rst_ovf",    DW'(overflow),     DW'(0));
        rst_n = 1'b1;
        @(negedge clock);

        // Place three known words in bank 0 through the append path, then reset:
        // reset must restore bank 0 as active with INIT_COUNT but keep its contents.
        do_swap();
        append(mk(1)); append(mk(2)); append(mk(3));
        do_swap();
        check("pre_active", DW'(active_count), cnt(3));
        rst_n = 1'b0;
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        @(negedge clock);

        add_read(0, cnt(3), 1'b0);
        add_read(1, mk(1), 1'b0);
        add_read(2, mk(2), 1'b0);
        add_read(3, mk(3), 1'b0);
        add_read(4, cnt(0), 1'b0);
        run_reads("init");

        // Append A..E into bank 1 and make it active.
        for (int i = 0; i < 5; i++) append(mk(16'hA + i));
        check("ae_shadow", DW'(shadow_count), cnt(5));
        do_swap();
        check("ae_active",    DW'(active_count), cnt(5));
        check("ae_shadow0",   DW'(shadow_count), cnt(0));
        add_read(0, cnt(5), 1'b0);
        add_read(6, cnt(0), 1'b0);
        for (int i = 0; i < 5; i++) add_read(i + 1, mk(16'hA + i), 1'b0);
        run_reads("ae");

        // Fill bank 0 past capacity: slot k holds mk(0x20+k).
        for (int k = 1; k <= 8; k++) begin
            append(mk(32'h20 + k));
            check($sformatf("fill_cnt%0d", k),  DW'(shadow_count), cnt((k < 7) ? k : 7));
            check($sformatf("fill_full%0d", k), DW'(shadow_full),  DW'(k >= 7));
            check($sformatf("fill_ovf%0d", k),  DW'(overflow),     DW'(k == 8));
        end
        check("fill_active", DW'(active_count), cnt(5));

        do_swap();
        check("full_active", DW'(active_count), cnt(7));
        check("full_shadow", DW'(shadow_count), cnt(0));
        check("full_clear",  DW'(shadow_full),  DW'(0));
        add_read(0, cnt(7), 1'b0);
        add_read(7, mk(32'h27), 1'b0);
        add_read(8, cnt(0), 1'b0);
        run_reads("full");

        // Append in the swap cycle joins the bank that becomes active.
        append(mk(32'h31)); append(mk(32'h32));
        check("ws_pre", DW'(shadow_count), cnt(2));
        wr_en = 1'b1; wr_data = mk(32'h3F); swap = 1'b1;
        @(negedge clock);
        wr_en = 1'b0; swap = 1'b0;
        check("ws_active", DW'(active_count), cnt(3));
        check("ws_shadow", DW'(shadow_count), cnt(0));
        check("ws_ovf",    DW'(overflow),     DW'(1));
        add_read(3, mk(32'h3F), 1'b0);
        add_read(1, mk(32'h31), 1'b0);
        add_read(4, cnt(0), 1'b0);
        run_reads("ws");

        // Reads up to and including the swap cycle use the old bank and count.
        append(mk(32'h41));
        add_read(1, mk(32'h31), 1'b0);
        add_read(2, mk(32'h32), 1'b1);
        add_read(1, mk(32'h41), 1'b0);
        add_read(2, cnt(0), 1'b0);
        run_reads("rs");
        check("rs_active", DW'(active_count), cnt(1));

        // Reset with two reads in flight: first just returned, second in the pipe.
        rd_en = 1'b1; rd_addr = AW'(1);
        @(negedge clock);
        @(posedge clock);
        #1;
        rd_en = 1'b0;
        check("mid_vld_pre", DW'(rd_valid), DW'(1));
        check("mid_dat_pre", rd_data, mk(32'h41));
        rst_n = 1'b0;
        #1;
        check("mid_vld",    DW'(rd_valid),     DW'(0));
        check("mid_data",   rd_data,           DW'(0));
        check("mid_active", DW'(active_count), cnt(INIT));
        check("mid_shadow", DW'(shadow_count), cnt(0));
        check("mid_ovf",    DW'(overflow),     DW'(0));
        repeat (2) @(negedge clock);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            check($sformatf("mid_flush%0d", c), DW'(rd_valid), DW'(0));
        end

        add_read(0, cnt(3), 1'b0);
        add_read(1, mk(32'h41), 1'b0);
        add_read(2, mk(32'h22), 1'b0);
        add_read(3, mk(32'h23), 1'b0);
        run_reads("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
